// File: rtl/s2p_pkg.sv
// s2p_pkg: shared state encoding and word-size constants for the S2P path
package s2p_pkg;
   localparam int N_DEF = 4;
   localparam int W = 2**N_DEF;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LOAD = 2'd2} state_t;
endpackage

// File: rtl/s2p_shift_ctrl_if.sv
// s2p_shift_ctrl_if: serial input / parallel word bundle between producer and S2P front end
interface s2p_shift_ctrl_if import s2p_pkg::*; #(parameter int N = N_DEF);
   logic sin, sin_valid, sync_clr, load_en, busy;
   logic [2**N-1:0] par_out;
   logic [N-1:0] bit_cnt;
   modport master(output sin, sin_valid, sync_clr, input par_out, load_en, busy, bit_cnt);
   modport slave(input sin, sin_valid, sync_clr, output par_out, load_en, busy, bit_cnt);
endinterface

// File: rtl/s2p_bit_counter.sv
// s2p_bit_counter: N-bit bit counter with clear, load-1 and natural-wrap increment
module s2p_bit_counter #(parameter int N = 4) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         load1,
   input  logic         inc,
   output logic [N-1:0] cnt
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (load1) cnt <= N'(1);
      else if (inc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/s2p_shift_ctrl.sv
// s2p_shift_ctrl: serial-to-parallel shifter with IDLE/SHIFT/LOAD word FSM and load strobe
// Define S2P_MSB_FIRST_EN for MSB-first shifting; default build is LSB-first.
module s2p_shift_ctrl import s2p_pkg::*; #(parameter int N = N_DEF) (
   input logic           clk,
   input logic           rst_n,
   s2p_shift_ctrl_if.slave bus
);
   localparam int WL = 2**N;
   state_t state, next;
   logic take, last;
   logic [WL-1:0] par;
   assign take = bus.sin_valid && !bus.sync_clr;
   assign last = bus.bit_cnt == N'(WL-1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;
   // a valid bit in LOAD starts the next word, so full-rate frames need no bubble
   always_comb begin
      next = IDLE;
      next = bus.sync_clr ? IDLE :
             state == SHIFT ? ((bus.sin_valid && last) ? LOAD : SHIFT) :
             bus.sin_valid ? SHIFT : IDLE;
   end
   s2p_bit_counter #(.N(N)) u_cnt (
      .clk(clk), .rst_n(rst_n), .clr(bus.sync_clr),
      .load1(take && state != SHIFT), .inc(take && state == SHIFT), .cnt(bus.bit_cnt)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) par <= '0;
      else if (bus.sync_clr) par <= '0;
`ifdef S2P_MSB_FIRST_EN
      else if (take) par <= {par[WL-2:0], bus.sin};
`else
      else if (take) par <= {bus.sin, par[WL-1:1]};
`endif
   assign bus.par_out = par;
   assign bus.busy = state == SHIFT;
   assign bus.load_en = state == LOAD;
endmodule
